// File: rtl/bf_pkg.sv
// Shared defaults and FSM encoding for the LSTM bias-buffer sequencer.
package bf_pkg;

  localparam int BF_D_WL      = 24;
  localparam int BF_UNITS_NUM = 5;
  localparam int BF_ENTRY_NUM = 6;
  localparam int BF_AW        = 8;
  localparam int BF_STEP_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } bf_state_e;

endpackage

// File: rtl/bf_out_slice.sv
// Single-stage valid/ready register slice carrying one bias word plus its
// entry/step indices and last flags towards the gate accumulators.
module bf_out_slice
  import bf_pkg::*;
#(
  parameter int DW     = BF_D_WL * BF_UNITS_NUM,
  parameter int AW     = BF_AW,
  parameter int STEP_W = BF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic [DW-1:0]     data_i,
  input  logic [AW-1:0]     entry_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              step_last_i,
  input  logic              run_last_i,
  input  logic              ready_i,
  output logic              take_o,
  output logic              accept_o,
  output logic              valid_o,
  output logic [DW-1:0]     data_o,
  output logic [AW-1:0]     entry_o,
  output logic [STEP_W-1:0] step_o,
  output logic              step_last_o,
  output logic              run_last_o
);

  logic              valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic [AW-1:0]     entry_q, entry_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              step_last_q, step_last_d;
  logic              run_last_q, run_last_d;
  logic              take_s, accept_s;

  assign take_s   = !valid_q || ready_i;
  assign accept_s = valid_q && ready_i;

  // Next-state: clear beats abort, a new load replaces the held beat.
  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    entry_d     = entry_q;
    step_d      = step_q;
    step_last_d = step_last_q;
    run_last_d  = run_last_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && take_s) begin
      valid_d     = 1'b1;
      data_d      = data_i;
      entry_d     = entry_i;
      step_d      = step_i;
      step_last_d = step_last_i;
      run_last_d  = run_last_i;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= {DW{1'b0}};
      entry_q     <= {AW{1'b0}};
      step_q      <= {STEP_W{1'b0}};
      step_last_q <= 1'b0;
      run_last_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      entry_q     <= entry_d;
      step_q      <= step_d;
      step_last_q <= step_last_d;
      run_last_q  <= run_last_d;
    end
  end

  assign take_o      = take_s;
  assign accept_o    = accept_s;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign entry_o     = entry_q;
  assign step_o      = step_q;
  assign step_last_o = step_last_q;
  assign run_last_o  = run_last_q;

endmodule

// File: rtl/bf_seq_ctrl.sv
// Bias-buffer sequencer: walks entries 0..ENTRY_NUM-1 for each of num_steps
// timesteps and streams the registered words through bf_out_slice.
module bf_seq_ctrl
  import bf_pkg::*;
#(
  parameter int D_WL      = BF_D_WL,
  parameter int UNITS_NUM = BF_UNITS_NUM,
  parameter int ENTRY_NUM = BF_ENTRY_NUM,
  parameter int AW        = BF_AW,
  parameter int STEP_W    = BF_STEP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_W-1:0]         num_steps,
  output logic [AW-1:0]             bf_addr,
  input  logic [UNITS_NUM*D_WL-1:0] bf_w_i,
  output logic [UNITS_NUM*D_WL-1:0] bias_o,
  output logic                      bias_valid,
  input  logic                      bias_ready,
  output logic [AW-1:0]             entry_idx,
  output logic [STEP_W-1:0]         step_idx,
  output logic                      step_last,
  output logic                      run_last,
  output logic                      busy,
  output logic                      done
);

  localparam int            DW         = UNITS_NUM * D_WL;
  localparam logic [AW-1:0] ENTRY_LAST = AW'(ENTRY_NUM - 1);

  bf_state_e         state_q, state_d;
  logic [AW-1:0]     entry_q, entry_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic src_valid_s, take_s, accept_s;
  logic ent_last_s, step_fin_s, run_last_s;

  // nsteps_q is never zero while in RUN, so the decrement cannot wrap.
  assign ent_last_s  = (entry_q == ENTRY_LAST);
  assign step_fin_s  = (step_q == (nsteps_q - STEP_W'(1)));
  assign run_last_s  = ent_last_s && step_fin_s;
  assign src_valid_s = (state_q == ST_RUN) && !abort;

  // Next-state, counter and status logic; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      entry_d = {AW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_steps != {STEP_W{1'b0}}) begin
              nsteps_d = num_steps;
              entry_d  = {AW{1'b0}};
              step_d   = {STEP_W{1'b0}};
              busy_d   = 1'b1;
              state_d  = ST_RUN;
            end else begin
              state_d = ST_FIN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (take_s) begin
            if (ent_last_s) begin
              entry_d = {AW{1'b0}};
              if (step_fin_s) begin
                state_d = ST_DRAIN;
              end else begin
                step_d = step_q + STEP_W'(1);
              end
            end else begin
              entry_d = entry_q + AW'(1);
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (accept_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      entry_q  <= {AW{1'b0}};
      step_q   <= {STEP_W{1'b0}};
      nsteps_q <= {STEP_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  bf_out_slice #(
    .DW     (DW),
    .AW     (AW),
    .STEP_W (STEP_W)
  ) u_slice (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (abort),
    .in_valid_i  (src_valid_s),
    .data_i      (bf_w_i),
    .entry_i     (entry_q),
    .step_i      (step_q),
    .step_last_i (ent_last_s),
    .run_last_i  (run_last_s),
    .ready_i     (bias_ready),
    .take_o      (take_s),
    .accept_o    (accept_s),
    .valid_o     (bias_valid),
    .data_o      (bias_o),
    .entry_o     (entry_idx),
    .step_o      (step_idx),
    .step_last_o (step_last),
    .run_last_o  (run_last)
  );

  // The entry counter doubles as the registered buffer address.
  assign bf_addr = entry_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bf_seq_ctrl.sv
// Directed bench for bf_seq_ctrl: vector table for the basic runs plus
// hand-written sequences for stalls, restart, mid-run reset and abort.
module tb_bf_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, abort, bias_ready;
  logic [15:0]  num_steps;
  logic [7:0]   bf_addr, entry_idx;
  logic [119:0] bf_w_i, bias_o;
  logic         bias_valid, step_last, run_last, busy, done;
  logic [15:0]  step_idx;
  logic [119:0] mem [0:7];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic        start;
    logic [15:0] nsteps;
    logic        ready;
    logic        e_valid, e_busy, e_done;
    logic [7:0]  e_entry;
    logic [15:0] e_step;
    logic        e_sl, e_rl;
  } vec_t;

  vec_t tbl[$];

  bf_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
    .bf_addr(bf_addr), .bf_w_i(bf_w_i), .bias_o(bias_o), .bias_valid(bias_valid),
    .bias_ready(bias_ready), .entry_idx(entry_idx), .step_idx(step_idx),
    .step_last(step_last), .run_last(run_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb bf_w_i = mem[bf_addr[2:0]];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [15:0] ns, input logic rdy,
                              input logic ev, input logic eb, input logic ed,
                              input logic [7:0] ee, input logic [15:0] es,
                              input logic esl, input logic erl);
    vec_t v;
    v.start = st; v.nsteps = ns; v.ready = rdy;
    v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
    v.e_entry = ee; v.e_step = es; v.e_sl = esl; v.e_rl = erl;
    return v;
  endfunction

  // Start a run of n steps and score every accepted beat against the buffer model.
  task automatic stream(input int n, input bit rnd, input int restart_cyc, input string tag);
    int k, dones, tail;
    logic prev_stall;
    logic [119:0] prev_bias;
    logic [7:0] prev_entry;
    @(negedge clk);
    start = 1'b1; num_steps = 16'(n); bias_ready = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0; num_steps = 16'(n + 3);
    k = 0; dones = 0; tail = 0; prev_stall = 1'b0;
    prev_bias = 120'd0; prev_entry = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (prev_stall)
        chk({tag, " stall_hold"}, {bias_valid, bias_o, entry_idx}, {1'b1, prev_bias, prev_entry});
      if (done) dones++;
      if (dones > 0) tail++;
      if (tail >= 4) break;
      start = (cyc == restart_cyc);
      bias_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bias_valid && bias_ready) begin
        chk({tag, " beat"}, {bias_o, entry_idx, step_idx, step_last, run_last},
            {mem[k % 6], 8'(k % 6), 16'(k / 6), (k % 6) == 5, k == 6 * n - 1});
        k++;
      end
      prev_stall = bias_valid && !bias_ready;
      prev_bias  = bias_o;
      prev_entry = entry_idx;
    end
    start = 1'b0;
    chk({tag, " beat_count"}, 160'(k), 160'(6 * n));
    chk({tag, " done_count"}, 160'(dones), 160'd1);
    chk({tag, " idle_after"}, {bias_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem[0] = 120'h002f41_004204_006276_0057ed_004aed;
    mem[1] = 120'h111111_222222_333333_444444_555555;
    mem[2] = 120'h0a0a0a_0b0b0b_0c0c0c_0d0d0d_0e0e0e;
    mem[3] = 120'h123456_789abc_def012_345678_9abcde;
    mem[4] = 120'hfedcba_987654_321000_abcdef_010203;
    mem[5] = 120'h002d1f_004ad4_003ec5_0032a2_00456a;
    mem[6] = 120'd0;
    mem[7] = 120'd0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bias_ready = 1'b0; num_steps = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {bf_addr, bias_o, bias_valid, entry_idx, step_idx, step_last, run_last, busy, done}, 160'd0);

    // one-step run with ready high, then a zero-step run
    tbl.push_back(mk(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1'b0, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'(i), 16'd0, i == 5, i == 5));
    tbl.push_back(mk(1'b0, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d ctrl", i), {bias_valid, busy, done},
          {tbl[i].e_valid, tbl[i].e_busy, tbl[i].e_done});
      if (tbl[i].e_valid)
        chk($sformatf("vec%0d beat", i), {bias_o, entry_idx, step_idx, step_last, run_last},
            {mem[tbl[i].e_entry[2:0]], tbl[i].e_entry, tbl[i].e_step, tbl[i].e_sl, tbl[i].e_rl});
      start = tbl[i].start; num_steps = tbl[i].nsteps; bias_ready = tbl[i].ready;
    end
    start = 1'b0;

    // three steps with random backpressure
    stream(3, 1'b1, -1, "rand3");
    // start re-asserted mid-run is ignored
    stream(2, 1'b0, 5, "restart2");

    // synchronous reset after beat 3
    @(negedge clk);
    start = 1'b1; num_steps = 16'd2; bias_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bias_valid && entry_idx == 8'd3) break;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midrun", {bf_addr, bias_o, bias_valid, entry_idx, step_idx, step_last, run_last, busy, done}, 160'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_quiet", {done, bias_valid, busy}, 3'b000);
    end
    stream(1, 1'b0, -1, "post_rst");

    // abort while stalled on beat 2
    @(negedge clk);
    start = 1'b1; num_steps = 16'd2; bias_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bias_valid && entry_idx == 8'd2) break;
    end
    bias_ready = 1'b0;
    @(negedge clk);
    chk("stall_beat2", {bias_valid, entry_idx}, {1'b1, 8'd2});
    abort = 1'b1;
    @(negedge clk);
    chk("abort", {bias_valid, busy, done}, 3'b000);
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_quiet", {bias_valid, busy, done}, 3'b000);
    end
    stream(1, 1'b1, -1, "post_abort");

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_steps = 16'd1; bias_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("start_abort", {bias_valid, busy, done}, 3'b000);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
